// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit.
// Holds the uop payload, access size/type enums, the FSM state enum and
// the data-memory strobe width.
package mem_access_unit_pkg;

    localparam int unsigned MAU_XLEN    = 32;
    localparam int unsigned DMEM_STRB_W = 4;
    localparam int unsigned PRF_IDX_W   = 6;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef enum logic {
        MEM_LD = 1'b0,
        MEM_ST = 1'b1
    } mem_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mau_state_t;

    typedef struct packed {
        logic                  valid;
        mem_type_t             mem_type;
        mem_size_t             mem_size;
        logic                  mem_unsigned;
        logic [MAU_XLEN-1:0]   imm;
        logic [PRF_IDX_W-1:0]  rd_prf_int_index;
    } micro_op_t;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// mem_load_align: combinational load-data alignment and extension.
// Ports:
//   i_rdata    raw memory word
//   i_off      byte offset of the access within the word
//   i_size     access size (B/H/W)
//   i_unsigned 1 = zero-extend, 0 = sign-extend
//   o_data     aligned, extended load result
module mem_load_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN = MAU_XLEN
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_off,
    input  mem_size_t       i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_shift;

    assign w_shift = i_rdata >> {i_off, 3'b000};

    // Extend the low byte/halfword of the lane-shifted word
    always_comb begin
        o_data = w_shift;
        case (i_size)
            MEM_B: o_data = i_unsigned ? XLEN'(w_shift[7:0])
                                       : {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
            MEM_H: o_data = i_unsigned ? XLEN'(w_shift[15:0])
                                       : {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
            default: o_data = w_shift;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-issue memory execution stage.
// Computes rs1+imm, issues one data-memory request, waits for the in-order
// response, aligns/extends load data and hands the uop to writeback.
// Optional feature macro: MAU_MISALIGN_CHECK_EN (misaligned H/W accesses
// complete immediately with wb_misalign=1 and no memory request).
// Ports:
//   clock, reset (async active-low), flush (sync kill)
//   uop_in, rs1_data, rs2_data  issued uop and operands
//   ex_busy                     unit cannot accept a uop
//   dmem_req_*                  request channel (valid/ready)
//   dmem_resp_*                 response pulse and raw read word
//   wb_uop, wb_data, wb_misalign writeback result
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN = MAU_XLEN
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  micro_op_t              uop_in,
    input  logic [XLEN-1:0]        rs1_data,
    input  logic [XLEN-1:0]        rs2_data,
    output logic                   ex_busy,
    output logic                   dmem_req_valid,
    input  logic                   dmem_req_ready,
    output logic [XLEN-1:0]        dmem_req_addr,
    output logic                   dmem_req_we,
    output logic [XLEN-1:0]        dmem_req_wdata,
    output logic [DMEM_STRB_W-1:0] dmem_req_wstrb,
    input  logic                   dmem_resp_valid,
    input  logic [XLEN-1:0]        dmem_resp_rdata,
    output micro_op_t              wb_uop,
    output logic [XLEN-1:0]        wb_data,
    output logic                   wb_misalign
);

    mau_state_t             r_state;
    mau_state_t             w_state_nxt;
    logic                   r_killed;
    logic                   w_killed_nxt;
    micro_op_t              r_uop;
    logic [XLEN-1:0]        r_addr;
    logic [XLEN-1:0]        r_wdata;
    logic [DMEM_STRB_W-1:0] r_wstrb;
    logic [XLEN-1:0]        r_wb_data;
    logic                   r_req_valid;
    logic                   r_busy;
    logic                   r_wb_valid;

    logic                   w_accept;
    logic                   w_is_store;
    logic [XLEN-1:0]        w_addr;
    logic [1:0]             w_off;
    logic [DMEM_STRB_W-1:0] w_wstrb;
    logic [XLEN-1:0]        w_wdata;
    logic                   w_misalign;
    logic [XLEN-1:0]        w_load_data;

    assign w_accept   = (r_state == ST_IDLE) && uop_in.valid && !flush;
    assign w_is_store = (uop_in.mem_type == MEM_ST);
    assign w_addr     = rs1_data + XLEN'(uop_in.imm);
    assign w_off      = w_addr[1:0];
    assign w_wdata    = w_is_store ? (rs2_data << {w_off, 3'b000}) : '0;

    // Byte enables; shifted strobes beyond lane 3 fall off the 4-bit field
    always_comb begin
        w_wstrb = '0;
        if (w_is_store) begin
            case (uop_in.mem_size)
                MEM_B:   w_wstrb = DMEM_STRB_W'(4'b0001 << w_off);
                MEM_H:   w_wstrb = DMEM_STRB_W'(4'b0011 << w_off);
                default: w_wstrb = 4'b1111;
            endcase
        end
    end

`ifdef MAU_MISALIGN_CHECK_EN
    logic r_misalign;

    assign w_misalign = ((uop_in.mem_size == MEM_H) && w_off[0]) ||
                        ((uop_in.mem_size == MEM_W) && (w_off != 2'b00));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        r_misalign <= 1'b0;
        else if (w_accept) r_misalign <= w_misalign;
    end

    assign wb_misalign = r_misalign;
`else
    assign w_misalign  = 1'b0;
    assign wb_misalign = 1'b0;
`endif

    mem_load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata    (dmem_resp_rdata),
        .i_off      (r_addr[1:0]),
        .i_size     (r_uop.mem_size),
        .i_unsigned (r_uop.mem_unsigned),
        .o_data     (w_load_data)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_killed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_killed <= w_killed_nxt;
        end
    end

    // Next state; a flush that races the request handshake must still drain the response
    always_comb begin
        w_state_nxt  = r_state;
        w_killed_nxt = r_killed;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = w_misalign ? ST_DONE : ST_REQ;
                    w_killed_nxt = 1'b0;
                end
            end
            ST_REQ: begin
                if (dmem_req_ready) begin
                    w_state_nxt  = ST_WAIT;
                    w_killed_nxt = flush;
                end else if (flush) begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush) w_killed_nxt = 1'b1;
                if (dmem_resp_valid)
                    w_state_nxt = (r_killed || flush) ? ST_IDLE : ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs and latched request payload
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_uop       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wb_data   <= '0;
            r_req_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else begin
            r_req_valid <= (w_state_nxt == ST_REQ);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_wb_valid  <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_uop     <= uop_in;
                r_addr    <= w_addr;
                r_wdata   <= w_wdata;
                r_wstrb   <= w_wstrb;
                r_wb_data <= '0;
            end else if ((r_state == ST_WAIT) && dmem_resp_valid &&
                         (r_uop.mem_type == MEM_LD)) begin
                r_wb_data <= w_load_data;
            end
        end
    end

    // Flush in DONE kills the writeback strobe in the same cycle
    always_comb begin
        wb_uop       = r_uop;
        wb_uop.valid = r_wb_valid && !flush;
    end

    assign ex_busy        = r_busy;
    assign dmem_req_valid = r_req_valid;
    assign dmem_req_addr  = {r_addr[XLEN-1:2], 2'b00};
    assign dmem_req_we    = (r_uop.mem_type == MEM_ST);
    assign dmem_req_wdata = r_wdata;
    assign dmem_req_wstrb = r_wstrb;
    assign wb_data        = r_wb_data;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            clock;
    logic            reset;
    logic            flush;
    micro_op_t       uop_in;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            ex_busy;
    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic [XLEN-1:0] dmem_req_addr;
    logic            dmem_req_we;
    logic [XLEN-1:0] dmem_req_wdata;
    logic [3:0]      dmem_req_wstrb;
    logic            dmem_resp_valid;
    logic [XLEN-1:0] dmem_resp_rdata;
    micro_op_t       wb_uop;
    logic [XLEN-1:0] wb_data;
    logic            wb_misalign;

    int n_tests;
    int n_fail;

    mem_access_unit #(.XLEN(XLEN)) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .uop_in          (uop_in),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .ex_busy         (ex_busy),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wstrb  (dmem_req_wstrb),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .wb_uop          (wb_uop),
        .wb_data         (wb_data),
        .wb_misalign     (wb_misalign)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a uop for one cycle; returns in cycle N+1
    task automatic issue(input mem_type_t t, input mem_size_t s, input logic u,
                         input logic [31:0] rs1, input logic [31:0] imm,
                         input logic [31:0] rs2, input logic [5:0] rd);
        uop_in                  = '0;
        uop_in.valid            = 1'b1;
        uop_in.mem_type         = t;
        uop_in.mem_size         = s;
        uop_in.mem_unsigned     = u;
        uop_in.imm              = imm;
        uop_in.rd_prf_int_index = rd;
        rs1_data                = rs1;
        rs2_data                = rs2;
        step();
        uop_in   = '0;
        rs1_data = '0;
        rs2_data = '0;
    endtask

    // Zero-wait memory: sample request at N+1, respond at N+2, sample wb at N+3, busy at N+4
    task automatic mem_zero_wait(input logic [31:0] rdata,
                                 output logic rv, output logic [31:0] ra,
                                 output logic we, output logic [31:0] wd,
                                 output logic [3:0] ws, output logic wbv,
                                 output logic [31:0] wbd, output logic [5:0] wbrd,
                                 output logic busy_after);
        rv = dmem_req_valid; ra = dmem_req_addr; we = dmem_req_we;
        wd = dmem_req_wdata; ws = dmem_req_wstrb;
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = rdata;
        step();
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = '0;
        wbv  = wb_uop.valid;
        wbd  = wb_data;
        wbrd = wb_uop.rd_prf_int_index;
        step();
        busy_after = ex_busy;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({ex_busy, dmem_req_valid, wb_uop.valid, wb_misalign} !== 4'b0000 ||
            wb_data !== 32'h0 || dmem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs busy=%b rv=%b wbv=%b mis=%b wbd=%h ra=%h expected all 0",
                     ex_busy, dmem_req_valid, wb_uop.valid, wb_misalign, wb_data, dmem_req_addr);
        end
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    task automatic test_lw();
        logic rv, we, wbv, busy; logic [31:0] ra, wd, wbd; logic [3:0] ws; logic [5:0] rd;
        issue(MEM_LD, MEM_W, 1'b0, 32'h1000, 32'd4, 32'h0, 6'd17);
        n_tests++;
        if (ex_busy !== 1'b1) begin
            n_fail++; $display("FAIL lw_busy_n1 got=%b exp=1", ex_busy);
        end
        mem_zero_wait(32'hDEADBEEF, rv, ra, we, wd, ws, wbv, wbd, rd, busy);
        n_tests++;
        if (rv !== 1'b1 || ra !== 32'h1004 || we !== 1'b0 || ws !== 4'b0000) begin
            n_fail++; $display("FAIL lw_req rv=%b addr=%h we=%b strb=%b exp 1/00001004/0/0000", rv, ra, we, ws);
        end
        n_tests++;
        if (wbv !== 1'b1 || wbd !== 32'hDEADBEEF || rd !== 6'd17) begin
            n_fail++; $display("FAIL lw_wb valid=%b data=%h rd=%0d exp 1/deadbeef/17", wbv, wbd, rd);
        end
        n_tests++;
        if (busy !== 1'b0 || wb_uop.valid !== 1'b0) begin
            n_fail++; $display("FAIL lw_n4 busy=%b wbv=%b exp 0/0", busy, wb_uop.valid);
        end
    endtask

    task automatic test_load_extend();
        logic rv, we, wbv, busy; logic [31:0] ra, wd, wbd; logic [3:0] ws; logic [5:0] rd;
        issue(MEM_LD, MEM_B, 1'b0, 32'h1000, 32'd3, 32'h0, 6'd1);
        mem_zero_wait(32'h80112233, rv, ra, we, wd, ws, wbv, wbd, rd, busy);
        n_tests++;
        if (ra !== 32'h1000 || wbv !== 1'b1 || wbd !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL lb_signed addr=%h wbv=%b data=%h exp 00001000/1/ffffff80", ra, wbv, wbd);
        end
        issue(MEM_LD, MEM_B, 1'b1, 32'h1000, 32'd3, 32'h0, 6'd2);
        mem_zero_wait(32'h80112233, rv, ra, we, wd, ws, wbv, wbd, rd, busy);
        n_tests++;
        if (wbv !== 1'b1 || wbd !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu wbv=%b data=%h exp 1/00000080", wbv, wbd);
        end
        // Negative immediate wraps: 0x1010 - 0xE = 0x1002
        issue(MEM_LD, MEM_H, 1'b0, 32'h1010, 32'hFFFFFFF2, 32'h0, 6'd3);
        mem_zero_wait(32'h80011234, rv, ra, we, wd, ws, wbv, wbd, rd, busy);
        n_tests++;
        if (ra !== 32'h1000 || wbd !== 32'hFFFF8001) begin
            n_fail++; $display("FAIL lh_signed addr=%h data=%h exp 00001000/ffff8001", ra, wbd);
        end
        issue(MEM_LD, MEM_H, 1'b1, 32'h1000, 32'd0, 32'h0, 6'd4);
        mem_zero_wait(32'h8001F234, rv, ra, we, wd, ws, wbv, wbd, rd, busy);
        n_tests++;
        if (wbd !== 32'h0000F234) begin
            n_fail++; $display("FAIL lhu data=%h exp 0000f234", wbd);
        end
    endtask

    task automatic test_store();
        logic rv, we, wbv, busy; logic [31:0] ra, wd, wbd; logic [3:0] ws; logic [5:0] rd;
        issue(MEM_ST, MEM_H, 1'b0, 32'h2000, 32'd2, 32'h0000ABCD, 6'd0);
        mem_zero_wait(32'h12345678, rv, ra, we, wd, ws, wbv, wbd, rd, busy);
        n_tests++;
        if (ra !== 32'h2000 || we !== 1'b1 || ws !== 4'b1100 || wd !== 32'hABCD0000) begin
            n_fail++; $display("FAIL sh_req addr=%h we=%b strb=%b wdata=%h exp 00002000/1/1100/abcd0000", ra, we, ws, wd);
        end
        n_tests++;
        if (wbv !== 1'b1 || wbd !== 32'h0) begin
            n_fail++; $display("FAIL sh_wb valid=%b data=%h exp 1/00000000", wbv, wbd);
        end
        issue(MEM_ST, MEM_B, 1'b0, 32'h2001, 32'd0, 32'h000000A5, 6'd0);
        mem_zero_wait(32'h0, rv, ra, we, wd, ws, wbv, wbd, rd, busy);
        n_tests++;
        if (ws !== 4'b0010 || wd !== 32'h0000A500) begin
            n_fail++; $display("FAIL sb_req strb=%b wdata=%h exp 0010/0000a500", ws, wd);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        int wb_cnt = 0;
        issue(MEM_LD, MEM_W, 1'b0, 32'h3000, 32'd8, 32'h0, 6'd9);
        dmem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 32'h3008 ||
                dmem_req_wstrb !== 4'b0000 || ex_busy !== 1'b1) bad++;
            step();
        end
        n_tests++;
        if (bad != 0 || dmem_req_valid !== 1'b1 || dmem_req_addr !== 32'h3008) begin
            n_fail++; $display("FAIL backpressure_hold bad_cycles=%0d rv=%b addr=%h exp 0/1/00003008", bad, dmem_req_valid, dmem_req_addr);
        end
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h0BADF00D;
        step();
        dmem_resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (wb_uop.valid === 1'b1) begin
                wb_cnt++;
                n_tests++;
                if (wb_data !== 32'h0BADF00D) begin
                    n_fail++; $display("FAIL backpressure_data got=%h exp 0badf00d", wb_data);
                end
            end
            step();
        end
        n_tests++;
        if (wb_cnt != 1) begin
            n_fail++; $display("FAIL backpressure_wb_count got=%0d exp 1", wb_cnt);
        end
    endtask

    task automatic test_flush_wait();
        int wb_cnt = 0;
        logic rv, we, wbv, busy; logic [31:0] ra, wd, wbd; logic [3:0] ws; logic [5:0] rd;
        issue(MEM_LD, MEM_W, 1'b0, 32'h4000, 32'd0, 32'h0, 6'd5);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        if (wb_uop.valid === 1'b1) wb_cnt++;
        step();
        if (wb_uop.valid === 1'b1) wb_cnt++;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h11112222;
        step();
        dmem_resp_valid = 1'b0;
        if (wb_uop.valid === 1'b1) wb_cnt++;
        n_tests++;
        if (wb_cnt != 0 || ex_busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_wait wb_count=%0d busy=%b exp 0/0", wb_cnt, ex_busy);
        end
        issue(MEM_LD, MEM_W, 1'b0, 32'h4000, 32'd4, 32'h0, 6'd6);
        mem_zero_wait(32'h33334444, rv, ra, we, wd, ws, wbv, wbd, rd, busy);
        n_tests++;
        if (rv !== 1'b1 || ra !== 32'h4004 || wbv !== 1'b1 || wbd !== 32'h33334444) begin
            n_fail++; $display("FAIL flush_recover rv=%b addr=%h wbv=%b data=%h exp 1/00004004/1/33334444", rv, ra, wbv, wbd);
        end
    endtask

    task automatic test_flush_req_done();
        issue(MEM_LD, MEM_W, 1'b0, 32'h5000, 32'd0, 32'h0, 6'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_tests++;
        if (ex_busy !== 1'b0 || dmem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_req busy=%b rv=%b exp 0/0", ex_busy, dmem_req_valid);
        end
        issue(MEM_LD, MEM_W, 1'b0, 32'h5000, 32'd0, 32'h0, 6'd7);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        step();
        dmem_resp_valid = 1'b0;
        flush = 1'b1;
        #1;
        n_tests++;
        if (wb_uop.valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_done wbv=%b exp 0", wb_uop.valid);
        end
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        int wb_cnt = 0;
        issue(MEM_LD, MEM_W, 1'b0, 32'h6000, 32'd0, 32'h0, 6'd8);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        reset = 1'b0;
        step();
        @(negedge clock);
        reset = 1'b1;
        step();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hCAFEF00D;
        step();
        dmem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (wb_uop.valid === 1'b1 || ex_busy === 1'b1) wb_cnt++;
            step();
        end
        n_tests++;
        if (wb_cnt != 0) begin
            n_fail++; $display("FAIL reset_mid_resp active_cycles=%0d exp 0", wb_cnt);
        end
    endtask

    task automatic test_misalign();
        logic rv, we, wbv, busy; logic [31:0] ra, wd, wbd; logic [3:0] ws; logic [5:0] rd;
        issue(MEM_LD, MEM_W, 1'b0, 32'h1000, 32'd2, 32'h0, 6'd10);
`ifdef MAU_MISALIGN_CHECK_EN
        n_tests++;
        if (dmem_req_valid !== 1'b0 || wb_uop.valid !== 1'b1 || wb_misalign !== 1'b1 || wb_data !== 32'h0) begin
            n_fail++; $display("FAIL misalign_lw rv=%b wbv=%b mis=%b data=%h exp 0/1/1/0",
                               dmem_req_valid, wb_uop.valid, wb_misalign, wb_data);
        end
        step();
        step();
`else
        mem_zero_wait(32'h89ABCDEF, rv, ra, we, wd, ws, wbv, wbd, rd, busy);
        n_tests++;
        if (rv !== 1'b1 || ra !== 32'h1000 || wbv !== 1'b1 || wb_misalign !== 1'b0) begin
            n_fail++; $display("FAIL misalign_lw rv=%b addr=%h wbv=%b mis=%b exp 1/00001000/1/0", rv, ra, wbv, wb_misalign);
        end
`endif
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        reset           = 1'b0;
        flush           = 1'b0;
        uop_in          = '0;
        rs1_data        = '0;
        rs2_data        = '0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = '0;
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_backpressure();
        test_flush_wait();
        test_flush_req_done();
        test_reset_mid();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
